// File: rtl/mem_arb_pkg.sv
// Shared definitions for the off-chip memory arbiter: FSM encoding,
// counter width helpers and the performance counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } arb_state_e;

   localparam int PERF_W = 16;

   // Beat counter must hold 0..BURST_LEN without wrapping.
   function automatic int beat_w(input int burst_len);
      return $clog2(burst_len + 2);
   endfunction

   function automatic int idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at/after ptr, else the
// lowest requester overall (wrap-around). The pointer register lives in the parent.
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   output logic [NUM_CH-1:0] gnt_oh,
   output logic [IDX_W-1:0]  gnt_idx,
   output logic              gnt_vld
);

   logic             lo_vld;
   logic             hi_vld;
   logic [IDX_W-1:0] lo_idx;
   logic [IDX_W-1:0] hi_idx;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      lo_vld = 1'b0;
      hi_vld = 1'b0;
      lo_idx = '0;
      hi_idx = '0;
      // Descending scan: the last hit is the lowest index in each class.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_vld = 1'b1;
            lo_idx = IDX_W'(i);
            if (IDX_W'(i) >= ptr) begin
               hi_vld = 1'b1;
               hi_idx = IDX_W'(i);
            end
         end
      end
      gnt_vld = lo_vld;
      gnt_idx = hi_vld ? hi_idx : lo_idx;
      gnt_oh  = NUM_CH'(lo_vld) << gnt_idx;
   end

endmodule

// File: rtl/offchip_mem_arbiter.sv
// Shares one off-chip memory port among NUM_CH cache clients, round-robin per
// whole block transaction. Define MEM_ARB_PERF_EN for per-channel perf counters.
module offchip_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 16,
   parameter int BURST_LEN = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        ch_rrqst,
   output logic [NUM_CH-1:0]        ch_rrdy,
   output logic [NUM_CH-1:0]        ch_rdrdy,
   input  logic [NUM_CH-1:0]        ch_rdacpt,
   input  logic [NUM_CH-1:0]        ch_wrqst,
   output logic [NUM_CH-1:0]        ch_wacpt,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic                     m_rrqst,
   output logic                     m_rdacpt,
   output logic                     m_wrqst,
   input  logic                     m_rrdy,
   input  logic                     m_rdrdy,
   input  logic                     m_wacpt,
   output logic [DATA_W-1:0]        m_wdata,
   input  logic [DATA_W-1:0]        m_rdata
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [NUM_CH*PERF_W-1:0] perf_txn_cnt,
   output logic [NUM_CH*PERF_W-1:0] perf_wait_cnt
`endif
);

   localparam int IDX_W  = idx_w(NUM_CH);
   localparam int BEAT_W = beat_w(BURST_LEN);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic [IDX_W-1:0]  ptr_q;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              beat_fire;
   logic              last_beat;

   logic [NUM_CH-1:0] req_any;
   logic [NUM_CH-1:0] arb_oh;
   logic [IDX_W-1:0]  arb_idx;
   logic              arb_vld;

   assign req_any  = ch_rrqst | ch_wrqst;
   assign ch_rdata = m_rdata;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_rr (
      .req     (req_any),
      .ptr     (ptr_q),
      .gnt_oh  (arb_oh),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      beat_d    = beat_q;
      beat_fire = 1'b0;
      last_beat = 1'b0;
      m_rrqst   = 1'b0;
      m_rdacpt  = 1'b0;
      m_wrqst   = 1'b0;
      m_wdata   = '0;
      ch_rrdy   = '0;
      ch_rdrdy  = '0;
      ch_wacpt  = '0;

      unique case (state_q)
         ST_IDLE: begin
            // A channel asking for both goes WR first: writeback before refill.
            if (arb_vld) begin
               grant_d = arb_idx;
               beat_d  = '0;
               state_d = (|(ch_wrqst & arb_oh)) ? ST_WR : ST_RD;
            end
         end
         ST_RD: begin
            m_rrqst           = ch_rrqst[grant_q];
            m_rdacpt          = ch_rdacpt[grant_q];
            m_wdata           = ch_wdata[grant_q*DATA_W +: DATA_W];
            ch_rrdy[grant_q]  = m_rrdy;
            ch_rdrdy[grant_q] = m_rdrdy;
            // Beat 0 is the address handshake; the rest are data words.
            beat_fire = (beat_q == '0) ? (ch_rrqst[grant_q] & m_rrdy)
                                       : (ch_rdacpt[grant_q] & m_rdrdy);
         end
         ST_WR: begin
            m_wrqst           = ch_wrqst[grant_q];
            m_wdata           = ch_wdata[grant_q*DATA_W +: DATA_W];
            ch_wacpt[grant_q] = m_wacpt;
            beat_fire         = ch_wrqst[grant_q] & m_wacpt;
         end
         default: state_d = ST_IDLE;
      endcase

      if (beat_fire) begin
         if (beat_q == LAST_BEAT) begin
            last_beat = 1'b1;
            state_d   = ST_IDLE;
            beat_d    = '0;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         beat_q  <= beat_d;
         if (last_beat)
            ptr_q <= (grant_q == IDX_W'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
      end
   end

`ifdef MEM_ARB_PERF_EN
   for (genvar i = 0; i < NUM_CH; i++) begin : g_perf
      logic              granted;
      logic [PERF_W-1:0] txn_q;
      logic [PERF_W-1:0] wait_q;

      assign granted = (state_q != ST_IDLE) && (grant_q == IDX_W'(i));

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            txn_q  <= '0;
            wait_q <= '0;
         end else begin
            if (last_beat && granted && (txn_q != '1))
               txn_q <= txn_q + 1'b1;
            if (req_any[i] && !granted && (wait_q != '1))
               wait_q <= wait_q + 1'b1;
         end
      end

      assign perf_txn_cnt[i*PERF_W +: PERF_W]  = txn_q;
      assign perf_wait_cnt[i*PERF_W +: PERF_W] = wait_q;
   end
`endif

endmodule

// File: tb/tb_offchip_mem_arbiter.sv
// Self-checking bench for offchip_mem_arbiter: behavioural clients, memory and
// a transaction-level arbitration model, directed scenarios plus random traffic.
module tb_offchip_mem_arbiter;

   localparam int NUM_CH    = 3;
   localparam int DATA_W    = 16;
   localparam int BURST_LEN = 4;

   logic                     clock = 1'b0;
   logic                     reset = 1'b1;
   logic [NUM_CH-1:0]        ch_rrqst, ch_rrdy, ch_rdrdy, ch_rdacpt, ch_wrqst, ch_wacpt;
   logic [NUM_CH*DATA_W-1:0] ch_wdata;
   logic [DATA_W-1:0]        ch_rdata, m_wdata, m_rdata;
   logic                     m_rrqst, m_rdacpt, m_wrqst, m_rrdy, m_rdrdy, m_wacpt;
`ifdef MEM_ARB_PERF_EN
   logic [NUM_CH*16-1:0]     perf_txn_cnt, perf_wait_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Client, memory and arbitration model state
   bit          cl_rd[NUM_CH], cl_wr[NUM_CH];
   int          rd_cnt[NUM_CH], wr_cnt[NUM_CH], rep[NUM_CH];
   logic [15:0] rd_addr[NUM_CH], wr_addr[NUM_CH];
   int          ref_wait[NUM_CH], ref_txn[NUM_CH];
   bit          busy, arb_wr, stall;
   int          arb_ch, ptr, mph, mcnt;
   logic [15:0] maddr;
   int          done_q[$];

   offchip_mem_arbiter #(
      .NUM_CH    (NUM_CH),
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .ch_rrqst  (ch_rrqst),
      .ch_rrdy   (ch_rrdy),
      .ch_rdrdy  (ch_rdrdy),
      .ch_rdacpt (ch_rdacpt),
      .ch_wrqst  (ch_wrqst),
      .ch_wacpt  (ch_wacpt),
      .ch_wdata  (ch_wdata),
      .ch_rdata  (ch_rdata),
      .m_rrqst   (m_rrqst),
      .m_rdacpt  (m_rdacpt),
      .m_wrqst   (m_wrqst),
      .m_rrdy    (m_rrdy),
      .m_rdrdy   (m_rdrdy),
      .m_wacpt   (m_wacpt),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_txn_cnt  (perf_txn_cnt),
      .perf_wait_cnt (perf_wait_cnt)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [15:0] rdat(input logic [15:0] a, input int k);
      return (a ^ 16'h3C5A) + 16'(k * 37);
   endfunction

   function automatic logic [15:0] wdat(input logic [15:0] a, input int k);
      return a + 16'(k * 3) + 16'h5000;
   endfunction

   function automatic bit rnd();
      return $urandom_range(3) != 0;
   endfunction

   function automatic bit any_active();
      bit a = 1'b0;
      for (int i = 0; i < NUM_CH; i++) a |= cl_rd[i] | cl_wr[i];
      return a;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NUM_CH; i++) begin
         cl_rd[i] = 0; cl_wr[i] = 0; rd_cnt[i] = 0; wr_cnt[i] = 0; rep[i] = 0;
         rd_addr[i] = '0; wr_addr[i] = '0; ref_wait[i] = 0; ref_txn[i] = 0;
      end
      busy = 0; arb_wr = 0; stall = 0; arb_ch = 0; ptr = 0; mph = 0; mcnt = 0; maddr = '0;
      done_q.delete();
   endtask

   task automatic drive();
      for (int i = 0; i < NUM_CH; i++) begin
         ch_rrqst[i]  = cl_rd[i];
         ch_wrqst[i]  = cl_wr[i];
         ch_rdacpt[i] = cl_rd[i] && rnd();
         ch_wdata[i*DATA_W +: DATA_W] = !cl_wr[i]       ? rd_addr[i] :
                                        (wr_cnt[i] == 0) ? wr_addr[i] :
                                        wdat(wr_addr[i], wr_cnt[i] - 1);
      end
      m_rrdy  = (mph == 0) && rnd();
      m_wacpt = (mph != 1) && rnd();
      m_rdrdy = (mph == 1) && !stall && rnd();
      m_rdata = (mph == 1) ? rdat(maddr, mcnt) : 16'($urandom);
   endtask

   task automatic finish_txn(input int g);
      done_q.push_back(g * 2 + (arb_wr ? 1 : 0));
      ref_txn[g]++;
      busy = 0;
      ptr  = (g + 1) % NUM_CH;
      mph  = 0;
      if (arb_wr) begin
         cl_wr[g] = 0; wr_cnt[g] = 0;
      end else begin
         cl_rd[g] = 0; rd_cnt[g] = 0;
         if (rep[g] > 0) begin
            rep[g]--; cl_rd[g] = 1; rd_addr[g] += 16'h10;
         end
      end
   endtask

   // Judges outputs for the upcoming edge and advances the model across it.
   task automatic evaluate();
      logic [NUM_CH-1:0] req, e_rrdy, e_rdrdy, e_wacpt;
      int g;
      check("rdata_bcast", ch_rdata, m_rdata);
      req = ch_rrqst | ch_wrqst;
      for (int i = 0; i < NUM_CH; i++)
         if (req[i] && !(busy && arb_ch == i)) ref_wait[i]++;
      if (!busy) begin
         check("idle_ch_out", {ch_rrdy, ch_rdrdy, ch_wacpt}, '0);
         check("idle_m_out", {m_rrqst, m_wrqst, m_rdacpt, m_wdata}, '0);
         for (int k = 0; k < NUM_CH; k++) begin
            int c = (ptr + k) % NUM_CH;
            if (!busy && req[c]) begin
               busy = 1; arb_ch = c; arb_wr = ch_wrqst[c];
            end
         end
         return;
      end
      g = arb_ch;
      e_rrdy = '0; e_rdrdy = '0; e_wacpt = '0;
      if (arb_wr) e_wacpt[g] = m_wacpt;
      else begin
         e_rrdy[g] = m_rrdy; e_rdrdy[g] = m_rdrdy;
      end
      check("ch_rrdy", ch_rrdy, e_rrdy);
      check("ch_rdrdy", ch_rdrdy, e_rdrdy);
      check("ch_wacpt", ch_wacpt, e_wacpt);
      check("m_rrqst", m_rrqst, !arb_wr && ch_rrqst[g]);
      check("m_wrqst", m_wrqst, arb_wr && ch_wrqst[g]);
      check("m_rdacpt", m_rdacpt, !arb_wr && ch_rdacpt[g]);
      check("m_wdata", m_wdata, ch_wdata[g*DATA_W +: DATA_W]);
      if (!arb_wr) begin
         if (rd_cnt[g] == 0) begin
            if (ch_rrqst[g] && m_rrdy) begin
               rd_cnt[g] = 1; mph = 1; maddr = rd_addr[g]; mcnt = 0;
            end
         end else if (ch_rdacpt[g] && m_rdrdy) begin
            check("rd_word", ch_rdata, rdat(rd_addr[g], rd_cnt[g] - 1));
            rd_cnt[g]++; mcnt++;
            if (rd_cnt[g] == BURST_LEN + 1) finish_txn(g);
         end
      end else if (ch_wrqst[g] && m_wacpt) begin
         wr_cnt[g]++; mph = 2;
         if (wr_cnt[g] == BURST_LEN + 1) finish_txn(g);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
      drive();
      #1;
      evaluate();
   endtask

   task automatic run_idle(input string tag, input int budget);
      int n = 0;
      do begin
         cycle();
         n++;
      end while ((busy || any_active()) && n < budget);
      check({tag, "_complete"}, busy || any_active(), 0);
   endtask

   task automatic expect_done(input string tag, input int code);
      int got = (done_q.size() > 0) ? done_q.pop_front() : -1;
      check(tag, got, code);
   endtask

   task automatic req_rd(input int c, input logic [15:0] a);
      cl_rd[c] = 1; rd_addr[c] = a; rd_cnt[c] = 0;
   endtask

   task automatic req_wr(input int c, input logic [15:0] a);
      cl_wr[c] = 1; wr_addr[c] = a; wr_cnt[c] = 0;
   endtask

   task automatic wait_rd_beats(input string tag, input int c, input int beats);
      int n = 0;
      while (rd_cnt[c] < beats && n < 200) begin
         cycle();
         n++;
      end
      check(tag, rd_cnt[c] >= beats, 1);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check("rst_ch_out", {ch_rrdy, ch_rdrdy, ch_wacpt}, '0);
      check("rst_m_out", {m_rrqst, m_wrqst, m_rdacpt, m_wdata}, '0);
      model_clear();
      drive();
      @(posedge clock);
      #2;
      reset = 1'b1;
   endtask

   initial begin
      model_clear();
      drive();
      #2 reset = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      check("reset_ch_out", {ch_rrdy, ch_rdrdy, ch_wacpt}, '0);
      check("reset_m_out", {m_rrqst, m_wrqst, m_rdacpt, m_wdata}, '0);
`ifdef MEM_ARB_PERF_EN
      check("reset_perf", {perf_txn_cnt, perf_wait_cnt}, '0);
`endif
      reset = 1'b1;

      // Single read on ch1
      req_rd(1, 16'h0100);
      run_idle("single_rd", 200);
      expect_done("single_rd_order", 2);

      // ch0 and ch1 together; ch0 comes back and waits behind ch1
      req_rd(0, 16'h0200);
      req_rd(1, 16'h0240);
      rep[0] = 1;
      run_idle("rr_pair", 400);
      expect_done("rr_first", 0);
      expect_done("rr_second", 2);
      expect_done("rr_third", 0);

      // Same channel read and write together: writeback first
      req_rd(1, 16'h0300);
      req_wr(1, 16'h0380);
      run_idle("wr_first", 400);
      expect_done("wr_first_order", 3);
      expect_done("rd_after_wr", 2);

      // Memory stall mid-burst while another channel requests
      req_rd(1, 16'h0400);
      wait_rd_beats("stall_reach", 1, 2);
      stall = 1;
      req_rd(0, 16'h0480);
      repeat (10) cycle();
      check("stall_beats", rd_cnt[1], 2);
      stall = 0;
      run_idle("stall", 400);
      expect_done("stall_first", 2);
      expect_done("stall_second", 0);

      // Reset mid-read: pointer returns to ch0
      req_rd(0, 16'h0500);
      run_idle("pre_reset", 200);
      expect_done("pre_reset_order", 0);
      req_rd(1, 16'h0540);
      wait_rd_beats("mid_rd_reach", 1, 2);
      do_reset();
      req_rd(1, 16'h0600);
      req_rd(0, 16'h0640);
      run_idle("post_reset", 400);
      expect_done("post_reset_first", 0);
      expect_done("post_reset_second", 2);

      // Random traffic
      for (int r = 0; r < 25; r++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            int kind = $urandom_range(3);
            if (kind == 1 || kind == 3) req_rd(i, 16'($urandom));
            if (kind == 2 || kind == 3) req_wr(i, 16'($urandom));
         end
         run_idle("random", 600);
         done_q.delete();
      end

`ifdef MEM_ARB_PERF_EN
      do_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         req_rd(i, 16'(16'h0700 + i * 16'h0100));
         rep[i] = 2;
      end
      run_idle("perf", 1000);
      cycle();
      for (int i = 0; i < NUM_CH; i++) begin
         check("perf_txn", perf_txn_cnt[i*16 +: 16], 3);
         check("perf_wait", perf_wait_cnt[i*16 +: 16], ref_wait[i]);
      end
      check("perf_wait_ch1_pos", perf_wait_cnt[16 +: 16] != 16'd0, 1);
      check("perf_wait_ch2_pos", perf_wait_cnt[32 +: 16] != 16'd0, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
